// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core MEM stage
// (port C) and an external loader/debug master (port X).
//
// Ports:
//   clk, reset                   clock, synchronous active-high reset
//   c_re, c_we, c_addr, c_wdata  core load/store request (store wins if both)
//   c_rdata, c_stall             core load data (combinational), stall
//   x_req, x_we, x_addr, x_wdata external request, held until x_gnt
//   x_gnt, x_rvalid, x_rdata     grant, read return one cycle after grant
//   mem_addr, mem_wdata, mem_we  to the data memory
//   mem_rdata                    from the data memory (combinational read)
//   err, err_src                 sticky bad-access flag and port of first error
module dmem_arbiter #(
    parameter int AW           = 32,
    parameter int DEPTH_WORDS  = 1024,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_re,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [31:0]   c_wdata,
    output logic [31:0]   c_rdata,
    output logic          c_stall,
    input  logic          x_req,
    input  logic          x_we,
    input  logic [AW-1:0] x_addr,
    input  logic [31:0]   x_wdata,
    output logic          x_gnt,
    output logic          x_rvalid,
    output logic [31:0]   x_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          mem_we,
    input  logic [31:0]   mem_rdata,
    output logic          err,
    output logic          err_src
);

    localparam logic [3:0]  LIMIT    = 4'(STARVE_LIMIT);
    // One bit wider than the address so DEPTH_WORDS*4 == 2**AW still fits.
    localparam logic [AW:0] ADDR_END = (AW+1)'(DEPTH_WORDS) << 2;

    logic [3:0]    r_starve;
    logic          r_rvalid;
    logic [31:0]   r_rdata;
    logic          r_err;
    logic          r_err_src;

    logic          w_c_req;
    logic          w_force_x;
    logic          w_gnt_x;
    logic          w_gnt_c;
    logic [AW-1:0] w_addr;
    logic          w_we;
    logic          w_bad;

    always_comb begin
        w_c_req   = c_re | c_we;
        w_force_x = x_req & (r_starve == LIMIT);
        w_gnt_x   = x_req & (w_force_x | ~w_c_req);
        w_gnt_c   = w_c_req & ~w_gnt_x;

        w_addr    = '0;
        w_we      = 1'b0;
        mem_wdata = '0;
        if (w_gnt_x) begin
            w_addr    = x_addr;
            w_we      = x_we;
            mem_wdata = x_wdata;
        end else if (w_gnt_c) begin
            w_addr    = c_addr;
            w_we      = c_we;
            mem_wdata = c_wdata;
        end

        w_bad = (w_gnt_x | w_gnt_c) &
                (({1'b0, w_addr} >= ADDR_END) | (w_addr[1:0] != 2'b00));

        mem_addr = w_addr;
        mem_we   = w_we & ~w_bad;
        c_rdata  = (w_gnt_c & ~w_bad) ? mem_rdata : '0;
        c_stall  = w_c_req & w_gnt_x;
        x_gnt    = w_gnt_x;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_starve  <= '0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_err_src <= 1'b0;
        end else begin
            if (x_req & ~w_gnt_x)
                r_starve <= (r_starve == LIMIT) ? LIMIT : r_starve + 4'd1;
            else
                r_starve <= '0;

            r_rvalid <= w_gnt_x & ~x_we;
            if (w_gnt_x & ~x_we)
                r_rdata <= w_bad ? '0 : mem_rdata;

            // Only the first bad access records its source port.
            if (w_bad & ~r_err) begin
                r_err     <= 1'b1;
                r_err_src <= w_gnt_x;
            end
        end
    end

    assign x_rvalid = r_rvalid;
    assign x_rdata  = r_rdata;
    assign err      = r_err;
    assign err_src  = r_err_src;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the core MEM stage (port C) and an external loader/debug master (port X).
- Sits between the EX/MEM pipeline register outputs and the data memory.
- Core accesses complete in the same cycle when granted; otherwise the core is stalled.
- X accesses use a req/gnt handshake, with read data returned one cycle after the grant.
- A starvation counter guarantees port X forward progress.

Parameters:
- AW, 32, address width of both ports and of the memory.
- DEPTH_WORDS, 1024, memory size in 32-bit words; byte addresses at or above DEPTH_WORDS*4 are out of range.
- STARVE_LIMIT, 4, consecutive denied X-request cycles before X is forced a grant; legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- c_re  in  1  core load request (MEM stage)
- c_we  in  1  core store request (MemWriteM)
- c_addr  in  AW  core byte address (ALUResultM)
- c_wdata  in  32  core store data (WriteDataM)
- c_rdata  out  32  core load data (ReadDataM), combinational from memory
- c_stall  out  1  core access denied this cycle; pipeline must hold
- x_req  in  1  external request; held until granted
- x_we  in  1  external write when 1, read when 0
- x_addr  in  AW  external byte address
- x_wdata  in  32  external write data
- x_gnt  out  1  external access performed this cycle
- x_rvalid  out  1  x_rdata valid; one-cycle pulse
- x_rdata  out  32  registered external read data
- mem_addr  out  AW  to data memory
- mem_wdata  out  32  to data memory
- mem_we  out  1  to data memory
- mem_rdata  in  32  from data memory, combinational read
- err  out  1  sticky out-of-range or misaligned access flag
- err_src  out  1  port of the first error: 0 = C, 1 = X

Behaviour:
- Reset (synchronous, active-high, clock edge with reset=1):
  - starve_cnt=0, x_rvalid=0, x_rdata=0, err=0, err_src=0.
  - Combinational outputs are at their idle values while requests are low.
  - Reset mid-operation discards any pending X read return: x_rvalid stays 0 next cycle.
- Core request: c_req = c_re | c_we. If c_re and c_we are both 1, treat as a store.
- Grant selection (combinational, each cycle):
  - force_x = x_req & (starve_cnt == STARVE_LIMIT).
  - Grant X if force_x, or if x_req & ~c_req.
  - Otherwise grant C if c_req.
  - Otherwise grant no one; mem_addr=0, mem_we=0.
- Grant C:
  - mem_* driven from port C; c_rdata = mem_rdata; c_stall = 0.
- Grant X:
  - mem_* driven from port X; x_gnt = 1.
  - c_stall = c_req.
  - c_rdata = 0 while stalled.
- Starvation counter:
  - starve_cnt increments, saturating at STARVE_LIMIT, when x_req=1 and x_gnt=0.
  - Clears when x_gnt=1 or x_req=0.
  - At most one forced X grant occurs per STARVE_LIMIT+1 cycles of continuous contention.
- X read return:
  - On a cycle with x_gnt & ~x_we: next cycle x_rvalid=1 and x_rdata = mem_rdata captured at the grant edge.
  - Otherwise x_rvalid=0 and x_rdata holds its last value.
- X handshake:
  - X must keep x_req/x_addr/x_we/x_wdata stable until x_gnt.
  - X may issue back-to-back requests; a new grant can coincide with x_rvalid of the previous read.
- Range and alignment check on the granted access:
  - The access is bad if addr >= DEPTH_WORDS*4 or addr[1:0] != 0.
  - A bad write is suppressed (mem_we=0).
  - A bad read returns 0 (c_rdata=0, or x_rdata=0 on return).
  - The handshake completes normally: no extra stall, x_gnt still asserted.
  - The first bad access sets err=1 and err_src to the granted port. Both are sticky until reset; later errors do not change err_src.
- Latency:
  - Core: 0 cycles when granted.
  - X: x_gnt in the request cycle if the core is idle, else within STARVE_LIMIT+1 cycles.
  - X read data: 1 cycle after x_gnt.

Test Plan:
- Core only: c_we=1, addr=0x10, data=0xDEADBEEF; next cycle c_re=1, addr=0x10 -> c_rdata=0xDEADBEEF, c_stall=0 both cycles.
- X only: x_req write addr=0x20, data=0x12345678 -> x_gnt same cycle; then X read of 0x20 -> x_gnt, next cycle x_rvalid=1 and x_rdata=0x12345678.
- Contention (STARVE_LIMIT=4): c_re held high, x_req held high from cycle 0.
  - Cycles 0-3: C granted, starve_cnt goes 1..4.
  - Cycle 4: x_gnt=1, c_stall=1.
  - Cycle 5: C granted, starve_cnt=0.
- Simultaneous request with core idle: x_req=1, c_req=0 -> x_gnt=1 immediately, starve_cnt stays 0.
- Errors:
  - C store to 0x1000 (DEPTH_WORDS=1024) -> mem_we=0, err=1, err_src=0.
  - Later X read of 0x2 -> x_rvalid with x_rdata=0; err_src still 0.
- Reset mid-read: reset asserted on the cycle of an X read grant -> next cycle x_rvalid=0, x_rdata=0, err=0, starve_cnt=0.
